// File: rtl/serial_bit_feeder.sv
// Parallel-in, serial-out feeder for the 1011 sequence detector: one word bit per clock on x.
// Next word can be accepted during the final bit, so consecutive words stream with no idle gap.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             at_last;
  logic             accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    at_last    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    load_ready = (state_q == IDLE) || at_last;
    accept     = load_valid && load_ready;

    // din is only looked at on an accept, so X on din elsewhere never reaches sreg.
    if (accept) begin
      sreg_d  = din;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
      if (at_last) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Serial outputs are a pure function of the registers.
  always_comb begin
    busy    = (state_q == SHIFT);
    x_valid = busy;
    last    = busy && (cnt_q == CNT_LAST);
    if (busy) begin
      x = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    end else begin
      x = IDLE_BIT;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: four parameterisations against a word/bit-position reference model.
module tb_serial_bit_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] din_a [4];
  logic [3:0]  lv_a;
  logic [3:0]  rdy_a, x_a, xv_a, last_a, busy_a;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
    .clk(clk), .reset(reset), .din(din_a[0][7:0]), .load_valid(lv_a[0]), .load_ready(rdy_a[0]),
    .x(x_a[0]), .x_valid(xv_a[0]), .last(last_a[0]), .busy(busy_a[0]));
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u1 (
    .clk(clk), .reset(reset), .din(din_a[1][7:0]), .load_valid(lv_a[1]), .load_ready(rdy_a[1]),
    .x(x_a[1]), .x_valid(xv_a[1]), .last(last_a[1]), .busy(busy_a[1]));
  serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u2 (
    .clk(clk), .reset(reset), .din(din_a[2][3:0]), .load_valid(lv_a[2]), .load_ready(rdy_a[2]),
    .x(x_a[2]), .x_valid(xv_a[2]), .last(last_a[2]), .busy(busy_a[2]));
  serial_bit_feeder #(.WIDTH(2), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u3 (
    .clk(clk), .reset(reset), .din(din_a[3][1:0]), .load_valid(lv_a[3]), .load_ready(rdy_a[3]),
    .x(x_a[3]), .x_valid(xv_a[3]), .last(last_a[3]), .busy(busy_a[3]));

  int n_checks = 0;
  int n_err    = 0;

  // Model: the word in flight and the index of the bit currently on x (-1 when nothing is in flight).
  int          pos  [4];
  logic [31:0] word [4];
  logic [31:0] cap  [4];
  int          vcnt [4];

  function automatic int w_of(input int i);
    case (i)
      0, 1:    return 8;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic msb_of(input int i);
    return (i == 0 || i == 2);
  endfunction

  function automatic logic idle_of(input int i);
    return (i >= 2);
  endfunction

  function automatic logic ready_exp(input int i);
    return (pos[i] < 0) || (pos[i] == w_of(i) - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input bit chk_rdy);
    for (int i = 0; i < 4; i++) begin
      int   w;
      logic ex;
      w = w_of(i);
      if (pos[i] < 0) ex = idle_of(i);
      else            ex = msb_of(i) ? word[i][w-1-pos[i]] : word[i][pos[i]];
      check($sformatf("x[%0d]", i),       {31'b0, x_a[i]},    {31'b0, ex});
      check($sformatf("x_valid[%0d]", i), {31'b0, xv_a[i]},   {31'b0, pos[i] >= 0});
      check($sformatf("busy[%0d]", i),    {31'b0, busy_a[i]}, {31'b0, pos[i] >= 0});
      check($sformatf("last[%0d]", i),    {31'b0, last_a[i]}, {31'b0, pos[i] == w - 1});
      if (chk_rdy)
        check($sformatf("load_ready[%0d]", i), {31'b0, rdy_a[i]}, {31'b0, ready_exp(i)});
      if (xv_a[i] === 1'b1) begin
        cap[i] = {cap[i][30:0], x_a[i]};
        vcnt[i]++;
      end
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 4; i++) begin
      if (lv_a[i] === 1'b1 && ready_exp(i)) begin
        word[i] = din_a[i];
        pos[i]  = 0;
      end else if (pos[i] >= 0) begin
        pos[i] = (pos[i] == w_of(i) - 1) ? -1 : pos[i] + 1;
      end
    end
  endtask

  // Entered and left at posedge+1 with inputs already driven.
  task automatic cycle();
    @(negedge clk);
    check_all(1'b1);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      lv_a[i]  = 1'b0;
      din_a[i] = 'x;
    end
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 4; i++) begin
      cap[i]  = '0;
      vcnt[i] = 0;
    end
  endtask

  task automatic load(input int i, input logic [31:0] d);
    lv_a[i]  = 1'b1;
    din_a[i] = d;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop without waiting for a clock edge.
  task automatic hit_reset();
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) pos[i] = -1;
    check_all(1'b0);
    idle_all();
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    lv_a  = '0;
    idle_all();
    clear_cap();
    for (int i = 0; i < 4; i++) begin
      pos[i]  = -1;
      word[i] = '0;
    end
    #3;
    check_all(1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single word 8'hB0, MSB first.
    clear_cap();
    load(0, 32'hB0);
    cycle();
    idle_all();
    repeat (9) cycle();
    check("b0_bits", cap[0] & 32'hFF, 32'hB0);
    check("b0_vcnt", vcnt[0], 8);

    // Back-to-back 8'hA5, 8'h3C with load_valid held.
    clear_cap();
    load(0, 32'hA5);
    cycle();
    load(0, 32'h3C);
    repeat (8) cycle();
    idle_all();
    repeat (9) cycle();
    check("b2b_bits", cap[0] & 32'hFFFF, 32'hA53C);
    check("b2b_vcnt", vcnt[0], 16);

    // Load 8'hFF; a mid-word load_valid pulse with 8'h00 must be ignored.
    clear_cap();
    load(0, 32'hFF);
    cycle();
    idle_all();
    repeat (2) cycle();
    load(0, 32'h00);
    cycle();
    idle_all();
    repeat (7) cycle();
    check("ff_bits", cap[0] & 32'hFF, 32'hFF);
    check("ff_vcnt", vcnt[0], 8);

    // Reset mid-word, then a clean 8'h0F.
    load(0, 32'hB0);
    cycle();
    idle_all();
    repeat (3) cycle();
    hit_reset();
    clear_cap();
    load(0, 32'h0F);
    cycle();
    idle_all();
    repeat (9) cycle();
    check("rst_bits", cap[0] & 32'hFF, 32'h0F);
    check("rst_vcnt", vcnt[0], 8);

    // LSB first: 8'h0D leaves as 1,0,1,1,0,0,0,0.
    clear_cap();
    load(1, 32'h0D);
    cycle();
    idle_all();
    repeat (9) cycle();
    check("lsb_bits", cap[1] & 32'hFF, 32'hB0);

    // WIDTH=4, IDLE_BIT=1: 4'h9, one idle cycle, 4'h6.
    clear_cap();
    load(2, 32'h9);
    cycle();
    idle_all();
    repeat (4) cycle();
    load(2, 32'h6);
    cycle();
    idle_all();
    repeat (5) cycle();
    check("w4_bits", cap[2] & 32'hFF, 32'h96);
    check("w4_vcnt", vcnt[2], 8);

    // Random traffic on all four instances, X on din whenever load_valid is low.
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 4; i++) begin
        lv_a[i]  = ($urandom_range(0, 3) != 0);
        din_a[i] = lv_a[i] ? $urandom : 'x;
      end
      if ($urandom_range(0, 199) == 0) hit_reset();
      else                             cycle();
    end
    idle_all();
    repeat (10) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-in, serial-out stage directly upstream of the 1011 Moore sequence detector.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Presents the word one bit per clock on x, which feeds the detector's serial input.
- Supports back-to-back words with no idle gap, so bit patterns that span word boundaries are detected.

Parameters:
- WIDTH, 8: bits per loaded word; legal range 2..32.
- MSB_FIRST, 1: 1 means din[WIDTH-1] goes out first; 0 means din[0] goes out first.
- IDLE_BIT, 0: value driven on x when no word is being shifted.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 resets; release is synchronous to clk).
- din  input  WIDTH  parallel word to serialize.
- load_valid  input  1  din is valid this cycle.
- load_ready  output  1  block accepts din at the next posedge if load_valid=1.
- x  output  1  serial bit to the sequence detector.
- x_valid  output  1  x carries a word bit this cycle.
- last  output  1  x carries the final bit of the current word.
- busy  output  1  state is SHIFT.

Behaviour:
- States: IDLE, SHIFT. A WIDTH-bit shift register sreg and a bit counter cnt (width clog2(WIDTH)) are held.
- Reset (reset=0, asynchronous): state=IDLE, sreg=0, cnt=0.
  - Outputs during and after reset: x=IDLE_BIT, x_valid=0, last=0, busy=0, load_ready=1 once reset=1.
- load_ready: combinational, = (state==IDLE) OR (state==SHIFT AND cnt==WIDTH-1).
- Accept: load_valid=1 AND load_ready=1 at a posedge.
  - sreg<=din, cnt<=0, state<=SHIFT.
  - din is sampled only at the accept edge; din changes at other times have no effect.
- Output derivation:
  - x = IDLE_BIT in IDLE.
  - x = sreg[WIDTH-1] in SHIFT when MSB_FIRST=1; x = sreg[0] in SHIFT when MSB_FIRST=0.
  - x_valid = busy = (state==SHIFT).
  - last = SHIFT AND cnt==WIDTH-1.
  - x, x_valid, last and busy depend only on registers, never on inputs.
- SHIFT, per posedge without accept:
  - sreg shifts toward the output end, filling with 0.
  - cnt increments.
  - When cnt==WIDTH-1: state<=IDLE, cnt<=0.
- SHIFT, last bit with accept (back-to-back): sreg<=din, cnt<=0, state stays SHIFT. The next bit is bit 0 of the new word with no gap cycle.
- Latency: word accepted at edge N; bit k is on x from edge N+k until edge N+k+1, and is sampled by the detector at edge N+k+1.
- Throughput: one word per WIDTH cycles under continuous load_valid.
- load_valid while SHIFT and cnt<WIDTH-1: ignored, no state change; the source must hold it (standard valid/ready).
- Reset mid-word: the in-flight word is discarded and no partial bits resume after release. Because x goes to IDLE_BIT, the detector receives no further word bits.
- The detector has no enable, so idle cycles emit IDLE_BIT. With IDLE_BIT=0, a partial 1011 match is broken by a gap. This is intended: only contiguous back-to-back words form cross-boundary matches.
- No overflow or underflow: the handshake makes loss impossible. An X on din outside accept edges must not propagate.

Test Plan:
- Reset, then load 8'hB0 (MSB_FIRST=1) -> x = 1,0,1,1,0,0,0,0 on 8 consecutive cycles starting the cycle after accept; x_valid=1 for exactly 8 cycles; last=1 only on the 8th. With the detector attached, z=1 in the cycle after the 4th bit is sampled.
- load_valid held with 8'hA5 then 8'h3C -> 16 contiguous valid bits 10100101 00111100, no gap. load_ready=1 only before the first accept and on cycle 8 (last); busy stays 1 across the word boundary.
- Load 8'hFF, then pulse load_valid with din=8'h00 at bit 3 -> pulse ignored; x stays 1 for all 8 bits; IDLE follows; x=0, x_valid=0.
- Load 8'hB0, then assert reset=0 asynchronously mid-cycle during bit 3 -> x_valid, busy and last drop to 0 immediately and x=IDLE_BIT. After release, load_ready=1 and the next load of 8'h0F shifts 0,0,0,0,1,1,1,1 cleanly.
- MSB_FIRST=0, load 8'h0D -> x = 1,0,1,1,0,0,0,0.
- WIDTH=4, IDLE_BIT=1, load 4'h9 with a 1-cycle gap, then 4'h6 -> x = 1,0,0,1,[1 idle, x_valid=0],0,1,1,0.
